// File: rtl/argmax_layer.sv
// Argmax classifier: captures one full vector of signed neuron outputs, scans it
// serially one element per cycle, and holds the index/value of the largest element.

module argmax_lane #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] d,
    output logic [DATA_WIDTH-1:0] q
);
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)      q <= '0;
        else if (load) q <= d;
    end
endmodule

module argmax_layer #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_INPUTS = 32,
    localparam int INDEX_WIDTH = $clog2(NUM_INPUTS)
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic                   argmax_ready_in,
    input  logic [NUM_INPUTS-1:0]  argmax_valid_in,
    input  logic [DATA_WIDTH-1:0]  argmax_data_in [0:NUM_INPUTS-1],
    input  logic                   argmax_ready_out,
    output logic                   argmax_valid_out,
    output logic [INDEX_WIDTH-1:0] argmax_class_out,
    output logic [DATA_WIDTH-1:0]  argmax_data_out
);
    localparam logic [INDEX_WIDTH-1:0] LAST_IDX = INDEX_WIDTH'(NUM_INPUTS - 1);

    typedef enum logic [1:0] {IDLE, SCAN, HOLD} state_t;

    typedef struct packed {
        logic [INDEX_WIDTH-1:0] idx;
        logic [DATA_WIDTH-1:0]  val;
    } best_t;

    state_t state, next_state;
    logic   alive;
    logic   accept;
    logic   last;
    logic   take;

    logic [NUM_INPUTS-1:0][DATA_WIDTH-1:0] buf_q;
    logic [INDEX_WIDTH-1:0]                scan_idx;
    logic [DATA_WIDTH-1:0]                 cur;
    best_t                                 best_q, best_nxt, res_q;

    // Ready must stay low while reset is held; this flag rises on the first edge after release.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) alive <= 1'b0;
        else      alive <= 1'b1;
    end

    assign accept = argmax_ready_in & (&argmax_valid_in);
    assign last   = (scan_idx == LAST_IDX);

    genvar i;
    generate
        for (i = 0; i < NUM_INPUTS; i++) begin : g_lane
            argmax_lane #(.DATA_WIDTH(DATA_WIDTH)) u_lane (
                .clk  (clk),
                .rst  (rst),
                .load (accept),
                .d    (argmax_data_in[i]),
                .q    (buf_q[i])
            );
        end
    endgenerate

    // Strict compare: ties keep the earlier (lower) index.
    assign cur      = buf_q[scan_idx];
    assign take     = $signed(cur) > $signed(best_q.val);
    assign best_nxt = take ? best_t'{idx: scan_idx, val: cur} : best_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept)           next_state = SCAN;
            SCAN:    if (last)             next_state = HOLD;
            HOLD:    if (argmax_ready_out) next_state = IDLE;
            default:                       next_state = IDLE;
        endcase
    end

    always_comb begin
        argmax_ready_in  = alive && (state == IDLE);
        argmax_valid_out = (state == HOLD);
    end

    // Result registers are separate from the running best so outputs survive the next capture.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            scan_idx <= '0;
            best_q   <= '0;
            res_q    <= '0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    best_q   <= best_t'{idx: '0, val: argmax_data_in[0]};
                    scan_idx <= INDEX_WIDTH'(1);
                end
                SCAN: begin
                    best_q   <= best_nxt;
                    scan_idx <= scan_idx + INDEX_WIDTH'(1);
                    if (last) res_q <= best_nxt;
                end
                default: ;
            endcase
        end
    end

    assign argmax_class_out = res_q.idx;
    assign argmax_data_out  = res_q.val;
endmodule
